// File: rtl/uart_io_bridge.sv
// Bridge between a byte-wide valid/ready core channel pair and an 8N1 UART line.
// TX and RX paths are independent, each buffered by a FIFO_DEPTH-entry FIFO.
module uart_io_bridge #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] io_o_data,
  input  logic       io_o_valid,
  output logic       io_o_ready,
  output logic [7:0] io_i_data,
  output logic       io_i_valid,
  input  logic       io_i_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  assign tx_empty   = (tx_wr == tx_rd);
  assign tx_full    = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign io_o_ready = ~tx_full & ~nrst;
  assign tx_push    = io_o_valid & io_o_ready;
  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop     = ~tx_empty & ((tx_state == IDLE) |
                                   ((tx_state == STOP) & (tx_cnt == BIT_LAST)));

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= io_o_data;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
    end
  end

  // uart_tx registers the bit of the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (nrst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= (tx_state == START) ? 1'b0 :
                 (tx_state == DATA)  ? tx_shift[0] : 1'b1;
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd[AW-1:0]];
            tx_cnt   <= '0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= DATA;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= STOP;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rd[AW-1:0]];
              tx_state <= START;
            end else tx_state <= IDLE;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_stop_sample;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_err_wait;

  assign rx_s           = rx_sync[1];
  assign rx_empty       = (rx_wr == rx_rd);
  assign rx_full        = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign io_i_valid     = ~rx_empty;
  assign io_i_data      = rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];
  assign rx_pop         = io_i_valid & io_i_ready;
  assign rx_stop_sample = (rx_state == STOP) & ~rx_err_wait & (rx_cnt == BIT_LAST);
  // A simultaneous pop frees the head slot, so a full FIFO can still take the byte.
  assign rx_push        = rx_stop_sample & rx_s & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_wr   <= '0;
      rx_rd   <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_err_wait  <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev & ~rx_s) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? IDLE : DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        STOP: begin
          // After a bad stop bit, hold here until the line returns high.
          if (rx_err_wait) begin
            if (rx_s) begin
              rx_err_wait <= 1'b0;
              rx_state    <= IDLE;
            end
          end else if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s) begin
              rx_overrun <= rx_full & ~rx_pop;
              rx_state   <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_err_wait  <= 1'b1;
            end
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Self-checking bench for uart_io_bridge: randomized bytes compared against
// ideal serial waveforms and FIFO ordering built from the 8N1 framing rules.
module tb_uart_io_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] io_o_data = 8'h00;
  logic       io_o_valid = 1'b0;
  logic       io_o_ready;
  logic [7:0] io_i_data;
  logic       io_i_valid;
  logic       io_i_ready = 1'b0;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       rx_frame_err;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic exp_line[$];

  uart_io_bridge #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .io_o_data(io_o_data), .io_o_valid(io_o_valid), .io_o_ready(io_o_ready),
    .io_i_data(io_i_data), .io_i_valid(io_i_valid), .io_i_ready(io_i_ready),
    .uart_tx(uart_tx), .uart_rx(uart_rx),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters: each count is the number of cycles the flag was high.
  always @(negedge clk) begin
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_overrun)   ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ideal 8N1 line image of one byte, one entry per clock cycle.
  task automatic add_frame(input logic [7:0] b);
    repeat (CPB) exp_line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) exp_line.push_back(b[i]);
    repeat (CPB) exp_line.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stop;
    repeat (CPB) tick();
    uart_rx = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic got);
    got = 1'b0;
    d   = 8'h00;
    for (int i = 0; i < 200 && !got; i++) begin
      if (io_i_valid === 1'b1) begin
        d = io_i_data;
        got = 1'b1;
        io_i_ready = 1'b1;
        tick();
        io_i_ready = 1'b0;
      end else tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    repeat (3) tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
    checks++; if (io_o_ready !== 1'b0) begin errors++; $display("FAIL reset_io_o_ready got %b want 0", io_o_ready); end
    checks++; if (io_i_valid !== 1'b0) begin errors++; $display("FAIL reset_io_i_valid got %b want 0", io_i_valid); end
    checks++; if (io_i_data !== 8'h00) begin errors++; $display("FAIL reset_io_i_data got %h want 00", io_i_data); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
    nrst = 1'b0;
    #1;
    checks++; if (io_o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", io_o_ready); end
    @(negedge clk);
  endtask

  task automatic test_tx_frame(input logic [7:0] b);
    exp_line.delete();
    add_frame(b);
    io_o_valid = 1'b1;
    io_o_data  = b;
    checks++; if (io_o_ready !== 1'b1) begin errors++; $display("FAIL tx_ready byte %h got %b want 1", b, io_o_ready); end
    @(posedge clk);
    @(negedge clk);
    io_o_valid = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n byte %h got %b want 1", b, uart_tx); end
    tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_latency_n1 byte %h got %b want 1", b, uart_tx); end
    for (int i = 0; i < exp_line.size(); i++) begin
      tick();
      checks++;
      if (uart_tx !== exp_line[i]) begin
        errors++;
        $display("FAIL tx_frame byte %h cycle %0d got %b want %b", b, i, uart_tx, exp_line[i]);
      end
    end
  endtask

  task automatic test_rx_hold();
    int fe0 = fe_cnt;
    io_i_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    repeat (CPB) tick();
    checks++; if (io_i_valid !== 1'b1) begin errors++; $display("FAIL rx_hold_valid got %b want 1", io_i_valid); end
    checks++; if (io_i_data !== 8'h3C) begin errors++; $display("FAIL rx_hold_data got %h want 3c", io_i_data); end
    repeat (20) tick();
    checks++; if (io_i_valid !== 1'b1 || io_i_data !== 8'h3C) begin
      errors++; $display("FAIL rx_hold_stable got %b/%h want 1/3c", io_i_valid, io_i_data);
    end
    io_i_ready = 1'b1;
    tick();
    io_i_ready = 1'b0;
    checks++; if (io_i_valid !== 1'b0) begin errors++; $display("FAIL rx_hold_pop got %b want 0", io_i_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL rx_hold_no_err got %0d want %0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    logic [7:0] d;
    logic got;
    io_i_ready = 1'b0;
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) tick();
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulse_cycles got %0d want 1", fe_cnt - fe0); end
    checks++; if (io_i_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_push got %b want 0", io_i_valid); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL ferr_no_overrun got %0d want %0d", ov_cnt, ov0); end
    send_frame(8'h12, 1'b1);
    read_byte(d, got);
    checks++; if (!got || d !== 8'h12) begin errors++; $display("FAIL ferr_recover got %h (valid seen %b) want 12", d, got); end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_single got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    logic [7:0] model[$];
    logic [7:0] b, d;
    logic got;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    io_i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      model.push_back(b);
      send_frame(b, 1'b1);
    end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL ovr_early got %0d want %0d", ov_cnt, ov0); end
    send_frame(8'($urandom), 1'b1);
    repeat (CPB) tick();
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_pulse got %0d want 1", ov_cnt - ov0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL ovr_no_ferr got %0d want %0d", fe_cnt, fe0); end
    for (int k = 0; k < DEPTH; k++) begin
      read_byte(d, got);
      checks++;
      if (!got || d !== model[k]) begin
        errors++; $display("FAIL ovr_readout entry %0d got %h (valid seen %b) want %h", k, d, got, model[k]);
      end
    end
    checks++; if (io_i_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b want 0", io_i_valid); end
  endtask

  task automatic test_glitch();
    logic [7:0] b, d;
    logic got;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (3 * CPB) tick();
    checks++; if (io_i_valid !== 1'b0) begin errors++; $display("FAIL glitch_push got %b want 0", io_i_valid); end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL glitch_pulses got fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    read_byte(d, got);
    checks++; if (!got || d !== b) begin errors++; $display("FAIL glitch_recover got %h (valid seen %b) want %h", d, got, b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx_bytes [17];
    logic [7:0] rx_bytes [4];
    logic [7:0] d;
    logic got;
    exp_line.delete();
    for (int k = 0; k < 17; k++) begin
      tx_bytes[k] = 8'($urandom);
      add_frame(tx_bytes[k]);
    end
    for (int k = 0; k < 4; k++) rx_bytes[k] = 8'($urandom);
    io_i_ready = 1'b0;
    fork
      begin : pusher
        for (int k = 0; k < 17; k++) begin
          io_o_valid = 1'b1;
          io_o_data  = tx_bytes[k];
          checks++; if (io_o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready push %0d got %b want 1", k, io_o_ready); end
          tick();
        end
        io_o_valid = 1'b0;
        // One byte is on the line, sixteen are buffered: the FIFO is full.
        checks++; if (io_o_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", io_o_ready); end
      end
      begin : sampler
        int waited = 0;
        while (uart_tx !== 1'b0 && waited < 100) begin
          tick();
          waited++;
        end
        checks++;
        if (uart_tx !== 1'b0) begin
          errors++; $display("FAIL b2b_start got %b want 0", uart_tx);
        end else begin
          for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if (uart_tx !== exp_line[i]) begin
              errors++; $display("FAIL b2b_line cycle %0d got %b want %b", i, uart_tx, exp_line[i]);
            end
            tick();
          end
        end
      end
      begin : rx_sender
        for (int k = 0; k < 4; k++) send_frame(rx_bytes[k], 1'b1);
      end
    join
    checks++; if (io_o_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained got %b want 1", io_o_ready); end
    for (int k = 0; k < 4; k++) begin
      read_byte(d, got);
      checks++;
      if (!got || d !== rx_bytes[k]) begin
        errors++; $display("FAIL duplex_rx entry %0d got %h (valid seen %b) want %h", k, d, got, rx_bytes[k]);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    int lows = 0;
    io_i_ready = 1'b0;
    send_frame(8'hC3, 1'b1);
    repeat (CPB) tick();
    checks++; if (io_i_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_rx got %b want 1", io_i_valid); end
    for (int k = 0; k < 3; k++) begin
      io_o_valid = 1'b1;
      io_o_data  = 8'h00;
      tick();
    end
    io_o_valid = 1'b0;
    repeat (8) tick();
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx got %b want 0", uart_tx); end
    nrst = 1'b1;
    tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", uart_tx); end
    checks++; if (io_o_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", io_o_ready); end
    checks++; if (io_i_valid !== 1'b0 || io_i_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_rx got %b/%h want 0/00", io_i_valid, io_i_data);
    end
    nrst = 1'b0;
    for (int i = 0; i < 12 * CPB; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_tx_flushed low cycles got %0d want 0", lows); end
    checks++; if (io_o_ready !== 1'b1 || io_i_valid !== 1'b0) begin
      errors++; $display("FAIL rst_fifos_empty got ready %b valid %b want 1 0", io_o_ready, io_i_valid);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'hA5);
    test_tx_frame(8'($urandom));
    test_tx_frame(8'($urandom));
    test_rx_hold();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_back_to_back();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_io_bridge.md
UART_IO_BRIDGE -- requirements
Module: uart_io_bridge

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, meaning clock cycles per UART bit; legal values are 4 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the entries per direction FIFO; it SHALL be a power of two, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: synchronous, active-high reset, asserted when 1 and sampled on the clk rising edge.
REQ-005 SHALL have port io_o_data, input, 8 bits: byte from the core's output channel.
REQ-006 SHALL have port io_o_valid, input, 1 bit: io_o_data is valid.
REQ-007 SHALL have port io_o_ready, output, 1 bit: the bridge accepts io_o_data.
REQ-008 SHALL have port io_i_data, output, 8 bits: received byte for the core's input channel.
REQ-009 SHALL have port io_i_valid, output, 1 bit: io_i_data is valid.
REQ-010 SHALL have port io_i_ready, input, 1 bit: the core consumes io_i_data.
REQ-011 SHALL have port uart_tx, output, 1 bit: serial line out, idle high.
REQ-012 SHALL have port uart_rx, input, 1 bit: serial line in, asynchronous, idle high.
REQ-013 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-014 SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when a received byte is dropped because the RX FIFO is full.

Function
REQ-015 Handshakes SHALL follow valid/ready: a transfer occurs on a rising edge where valid and ready are both 1; valid and data SHALL NOT depend combinationally on ready.
REQ-016 io_o_ready SHALL equal "TX FIFO not full", computed from registered state only; a push while full is impossible, even if a pop happens in the same cycle.
REQ-017 The TX FIFO SHALL accept a push and a pop in the same cycle at any occupancy; occupancy is unchanged in that case.
REQ-018 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are distinguished by the MSB.
REQ-019 The TX FSM SHALL have states IDLE, START, DATA and STOP, with these transitions:
- IDLE -> START when the TX FIFO is non-empty; the FSM pops the head byte in that same cycle.
- START: uart_tx=0 for CLK_PER_BIT cycles, then -> DATA.
- DATA: 8 bits, LSB first, CLK_PER_BIT cycles each, then -> STOP.
- STOP: uart_tx=1 for CLK_PER_BIT cycles, then -> IDLE.
REQ-020 For a byte accepted at edge N into an empty, idle TX path, uart_tx SHALL go low after edge N+2.
REQ-021 Back-to-back frames SHALL have no idle gap: if the FIFO is non-empty when STOP ends, the next START follows immediately.
REQ-022 uart_tx SHALL be driven from a register.
REQ-023 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-024 The RX FSM SHALL have states IDLE, START, DATA and STOP, with these transitions:
- IDLE -> START on a synchronized high-to-low transition.
- START: wait CLK_PER_BIT/2 cycles (integer division), then sample. If the sample is 1, the start was false -> IDLE with no pulse; otherwise -> DATA.
- DATA: sample every CLK_PER_BIT cycles, 8 bits, LSB first, then -> STOP.
- STOP: sample after CLK_PER_BIT cycles.
REQ-025 On a STOP sample of 1 with the RX FIFO not full, the bridge SHALL push the byte.
REQ-026 On a STOP sample of 1 with the RX FIFO full, the bridge SHALL discard the byte and pulse rx_overrun for one cycle.
REQ-027 On a STOP sample of 0, the bridge SHALL discard the byte and pulse rx_frame_err for one cycle, then return to IDLE only after the synchronized line reads 1.
REQ-028 The RX FIFO SHALL be first-word fall-through: io_i_valid = "not empty" and io_i_data = head entry, both registered or derived from registered state.
REQ-029 A pop occurs when io_i_valid and io_i_ready are both 1.
REQ-030 An RX push into an empty FIFO SHALL raise io_i_valid on the following cycle.
REQ-031 An RX pop and an RX push in the same cycle, including when full, SHALL both succeed; full is evaluated before the pop.
REQ-032 The TX and RX paths SHALL be fully independent; full-duplex operation SHALL not stall either path.

Reset
REQ-033 While nrst=1, the bridge SHALL drive: uart_tx=1, io_o_ready=0, io_i_valid=0, io_i_data=0, rx_frame_err=0, rx_overrun=0.
REQ-034 While nrst=1, both FIFOs SHALL be emptied, both FSMs set to IDLE, all counters cleared, and the synchronizer set to 1.
REQ-035 In the first cycle after nrst deasserts, io_o_ready SHALL be 1.
REQ-036 Reset asserted mid-frame SHALL abort the frame; uart_tx SHALL be 1 on the next edge and no partial byte SHALL be pushed.

Verification
REQ-037 (CLK_PER_BIT=4) Push 0xA5 at edge N -> uart_tx is low for 4 cycles starting after edge N+2, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles.
REQ-038 Push 17 bytes with FIFO_DEPTH=16 while the line is busy -> io_o_ready drops once 16 are buffered; all 17 bytes appear on uart_tx in order with no gaps.
REQ-039 Drive frame 0x3C on uart_rx with io_i_ready=0 -> io_i_valid rises and io_i_data=0x3C; it holds until io_i_ready=1, then io_i_valid falls.
REQ-040 Drive frame 0x55 with stop bit 0 -> rx_frame_err pulses for exactly 1 cycle, io_i_valid stays 0, and the next good frame 0x12 is received.
REQ-041 Fill the RX FIFO with 16 frames and io_i_ready=0, then send a 17th -> rx_overrun pulses once, and the 16 entries read out unchanged.
REQ-042 A 1-cycle low glitch on uart_rx -> no push and no error pulses; also assert nrst mid-TX-frame -> uart_tx=1 next edge and the FIFOs are empty.
